// File: rtl/merger_pkg.sv
// Shared types and constants for the merger output collector.
package merger_pkg;

  localparam int DATA_W    = 32;
  // Cycles from o_stall_req rising to the merger pipeline actually holding off
  localparam int STALL_RTT = 2;

  typedef struct packed {
    logic              sw;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e0;
  } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous pair FIFO; head entry is read combinationally, pointers wrap modulo DEPTH.
module pair_fifo
  import merger_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = pair_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/merger_output_collector.sv
// Buffers sorted pairs from the compare-swap stage and serializes them into a valid/ready stream.
// Optional ORDER_CHECK_EN adds a sticky o_order_err for non-monotonic elements within a run.
module merger_output_collector
  import merger_pkg::*;
#(
  parameter int DATA_W    = merger_pkg::DATA_W,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_elems_0,
  input  logic [DATA_W-1:0] i_elems_1,
  input  logic              i_switch_output,
  input  logic              i_stall,
  output logic              o_stall_req,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
`ifdef ORDER_CHECK_EN
  output logic              o_order_err,
`endif
  output logic              o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (AF_MARGIN < STALL_RTT) begin : g_bad_margin
    $error("AF_MARGIN must cover the upstream stall round-trip");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end

  typedef struct packed {
    logic              sw;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e0;
  } entry_t;

  entry_t          fifo_wdata, fifo_head;
  logic [CW-1:0]   fifo_count, count_next;
  logic            fifo_full, fifo_empty;
  logic            load_en, push, pop;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              stall_req_q, stall_req_d;
  logic              overflow_q, overflow_d;

  assign fifo_wdata = '{sw: i_switch_output, e1: i_elems_1, e0: i_elems_0};

  pair_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    load_en = !valid_q || i_ready;
    pop     = load_en && !fifo_empty && sel_q;
    // A full FIFO still accepts when its head leaves in the same cycle
    push    = !i_stall && (!fifo_full || pop);

    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (load_en) begin
      if (fifo_empty) begin
        valid_d = 1'b0;
      end else if (!sel_q) begin
        valid_d = 1'b1;
        data_d  = fifo_head.e0;
        last_d  = 1'b0;
        sel_d   = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = fifo_head.e1;
        last_d  = fifo_head.sw;
        sel_d   = 1'b0;
      end
    end

    count_next  = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    stall_req_d = (count_next >= CW'(DEPTH - AF_MARGIN));
    overflow_d  = overflow_q || (!i_stall && !push);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      sel_q       <= 1'b0;
      stall_req_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      stall_req_q <= stall_req_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_last      = last_q;
  assign o_stall_req = stall_req_q;
  assign o_overflow  = overflow_q;

`ifdef ORDER_CHECK_EN
  logic              accept;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              run_q, run_d;
  logic              order_err_q, order_err_d;

  always_comb begin
    accept      = valid_q && i_ready;
    prev_d      = prev_q;
    run_d       = run_q;
    order_err_d = order_err_q;
    if (accept) begin
      if (run_q && (data_q < prev_q)) order_err_d = 1'b1;
      prev_d = data_q;
      run_d  = !last_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q      <= '0;
      run_q       <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      run_q       <= run_d;
      order_err_q <= order_err_d;
    end
  end

  assign o_order_err = order_err_q;
`endif

endmodule

// File: tb/tb_merger_output_collector.sv
// Directed bench for merger_output_collector: expected stream kept in a queue, checked on accept.
module tb_merger_output_collector;

  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [DW-1:0] i_elems_0 = '0;
  logic [DW-1:0] i_elems_1 = '0;
  logic          i_switch_output = 1'b0;
  logic          i_stall = 1'b1;
  logic          i_ready = 1'b1;
  logic          o_stall_req;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          o_overflow;
`ifdef ORDER_CHECK_EN
  logic          o_order_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q[$];

  merger_output_collector #(
    .DATA_W    (DW),
    .DEPTH     (8),
    .AF_MARGIN (2)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_elems_0       (i_elems_0),
    .i_elems_1       (i_elems_1),
    .i_switch_output (i_switch_output),
    .i_stall         (i_stall),
    .o_stall_req     (o_stall_req),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_last          (o_last),
`ifdef ORDER_CHECK_EN
    .o_order_err     (o_order_err),
`endif
    .o_overflow      (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Presents one pair for the next edge, then returns one cycle later with the pair taken.
  task automatic push_pair(input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic sw,
                           input bit expect_kept);
    i_elems_0       = e0;
    i_elems_1       = e1;
    i_switch_output = sw;
    i_stall         = 1'b0;
    if (expect_kept) begin
      exp_q.push_back({1'b0, e0});
      exp_q.push_back({sw, e1});
    end
    step();
    i_stall = 1'b1;
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    i_ready = 1'b1;
    i_stall = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && cyc < 300) begin
      step();
      cyc++;
    end
    check_val({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Every accepted element must be the next expected one, including its o_last flag.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check_val("stream_extra", {31'd0, o_last, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check_val("stream", {31'd0, o_last, o_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // reset values
    i_rst_n = 1'b0;
    step(2);
    check_val("rst_valid",   o_valid, 0);
    check_val("rst_data",    o_data, 0);
    check_val("rst_last",    o_last, 0);
    check_val("rst_stall",   o_stall_req, 0);
    check_val("rst_ovf",     o_overflow, 0);
    i_rst_n = 1'b1;
    step(2);

    // single pair latency
    i_ready = 1'b1;
    push_pair(32'd5, 32'd9, 1'b1, 1'b1);
    check_val("single_n_valid", o_valid, 0);
    step();
    check_val("single_e0", {o_valid, o_last, o_data}, {1'b1, 1'b0, 32'd5});
    step();
    check_val("single_e1", {o_valid, o_last, o_data}, {1'b1, 1'b1, 32'd9});
    step();
    check_val("single_idle", o_valid, 0);

    // fill to the stall threshold with downstream blocked, honoring stall two cycles late
    i_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push_pair(32'(2*k-1), 32'(2*k), (k == 8), 1'b1);
      if (k == 5) check_val("af_below", o_stall_req, 0);
      if (k == 6) check_val("af_reached", o_stall_req, 1);
    end
    check_val("af_held", o_stall_req, 1);
    check_val("af_no_ovf", o_overflow, 0);
    check_val("af_head", {o_valid, o_data}, {1'b1, 32'd1});
    drain("af");
    check_val("af_released", o_stall_req, 0);

    // ignore stall: ninth pair dropped
    i_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push_pair(32'(100+2*k), 32'(101+2*k), (k == 8), 1'b1);
    check_val("ovf_before", o_overflow, 0);
    push_pair(32'hBAD0, 32'hBAD1, 1'b1, 1'b0);
    check_val("ovf_set", o_overflow, 1);
    drain("ovf");
    check_val("ovf_sticky", o_overflow, 1);

    // asynchronous reset with three pairs buffered
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_pair(32'(50+k), 32'(60+k), 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val("arst_valid", o_valid, 0);
    check_val("arst_data",  o_data, 0);
    check_val("arst_stall", o_stall_req, 0);
    check_val("arst_ovf",   o_overflow, 0);
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    step(6);
    check_val("arst_no_stale", o_valid, 0);

    // alternating stall with garbage held while stalled
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        push_pair(32'(200+i), 32'(300+i), (i == 8), 1'b1);
      end else begin
        i_elems_0 = 32'hDEAD_BEEF;
        i_elems_1 = 32'hCAFE_F00D;
        i_switch_output = 1'b1;
        i_stall = 1'b1;
        step();
      end
    end
    drain("toggle");
    check_val("toggle_no_ovf", o_overflow, 0);

`ifdef ORDER_CHECK_EN
    push_pair(32'd2, 32'd7, 1'b1, 1'b1);
    push_pair(32'd1, 32'd3, 1'b0, 1'b1);
    push_pair(32'd5, 32'd8, 1'b1, 1'b1);
    drain("ord_ok");
    check_val("ord_clean", o_order_err, 0);
    push_pair(32'd10, 32'd12, 1'b0, 1'b1);
    push_pair(32'd4, 32'd5, 1'b1, 1'b1);
    drain("ord_bad");
    check_val("ord_flag", o_order_err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
